// File: rtl/pipe_sram_1w1r.sv
// pipe_sram_1w1r
//   Single-clock synchronous RAM with one write port and one read port.
//   Writes are masked per lane. Read data is registered and qualified by a
//   one-cycle valid pulse. After every reset a hardware sweep zeroes the
//   whole array before requests are accepted. A write and a read to the same
//   address on the same edge either forward the new data (BYPASS=1) or
//   return the old word (BYPASS=0).
//
// Ports
//   clk      single clock, all state updates on the rising edge
//   rst      synchronous active-high reset, restarts the zeroing sweep
//   ready    high once the sweep has finished; requests accepted only then
//   csb0     write select, active low
//   wmask0   per-lane write enables, bit i covers din0[i*BYTE_WIDTH +: BYTE_WIDTH]
//   addr0    write address
//   din0     write data
//   csb1     read select, active low
//   addr1    read address
//   dout1    registered read data, held between reads
//   rvalid1  one-cycle pulse after each accepted read

module pipe_sram_1w1r #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 4,
  parameter int BYTE_WIDTH = 8,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               ready,
  input  logic                               csb0,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wmask0,
  input  logic [ADDR_WIDTH-1:0]              addr0,
  input  logic [DATA_WIDTH-1:0]              din0,
  input  logic                               csb1,
  input  logic [ADDR_WIDTH-1:0]              addr1,
  output logic [DATA_WIDTH-1:0]              dout1,
  output logic                               rvalid1
);

  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int NUM_WMASKS = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  // A partial lane would leave bits that no mask bit can reach.
  generate
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_geometry
      $error("pipe_sram_1w1r: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
  endgenerate

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]   merged;
  logic [DATA_WIDTH-1:0]   read_word;
  logic                    collide;

  // The word the write port will leave behind: old content with the
  // enabled lanes replaced by din0. Also used as the forwarded read value.
  always_comb begin
    merged = mem[addr0];
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (wmask0[i]) begin
        merged[i*BYTE_WIDTH +: BYTE_WIDTH] = din0[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Only an accepted write at the same address can collide with a read.
  assign collide   = !csb0 && (addr0 == addr1);
  assign read_word = (BYPASS && collide) ? merged : mem[addr1];

  // INIT zeroes one entry per edge and ignores both ports; the edge that
  // clears the last entry raises ready. READY serves both ports every edge
  // and is left only through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      ptr     <= '0;
      ready   <= 1'b0;
      rvalid1 <= 1'b0;
      dout1   <= '0;
    end else begin
      unique case (state)
        INIT: begin
          mem[ptr] <= '0;
          ptr      <= ptr + 1'b1;
          rvalid1  <= 1'b0;
          if (ptr == LAST_ADDR) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          if (!csb0) begin
            mem[addr0] <= merged;
          end
          if (!csb1) begin
            dout1   <= read_word;
            rvalid1 <= 1'b1;
          end else begin
            rvalid1 <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
